// File: rtl/int_to_fp_pkg.sv
// Shared widths, limits and FSM state encoding for the integer-to-FP converter.
package int_to_fp_pkg;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;

  localparam logic [EXP_W-1:0]  EXP_MAX  = '1;
  localparam logic [FRAC_W-1:0] FRAC_MAX = '1;
  localparam logic [FRAC_W-1:0] FRAC_ONE = {1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/int_to_fp_round_rne.sv
// Combinational rounder: normalized frac/exp plus guard/round/sticky in, rounded frac/exp/ovf out.
// Rounds to nearest even when I2F_ROUND_EN is defined, otherwise truncates.
module fp_round_rne
  import int_to_fp_pkg::*;
(
  input  logic [FRAC_W-1:0] frac_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic              g_i,
  input  logic              r_i,
  input  logic              s_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic              ovf_o
);

  logic            inc;
  logic [FRAC_W:0] sum;

`ifdef I2F_ROUND_EN
  assign inc = g_i & (r_i | s_i | frac_i[0]);
`else
  logic unused_grs;
  assign unused_grs = g_i | r_i | s_i;
  assign inc        = 1'b0;
`endif

  assign sum = {1'b0, frac_i} + {{FRAC_W{1'b0}}, inc};

  always_comb begin
    frac_o = sum[FRAC_W-1:0];
    exp_o  = exp_i;
    ovf_o  = 1'b0;
    if (sum[FRAC_W]) begin
      // Carry out of the fraction renormalizes to 0.1000_0000 one exponent up.
      if (exp_i == EXP_MAX) begin
        frac_o = FRAC_MAX;
        exp_o  = EXP_MAX;
        ovf_o  = 1'b1;
      end else begin
        frac_o = FRAC_ONE;
        exp_o  = exp_i + 4'd1;
      end
    end
  end

endmodule

// File: rtl/int_to_fp.sv
// Sequential signed-integer to FP converter: one normalizing shift per cycle, then round.
// Rounding mode selected by I2F_ROUND_EN (nearest-even when defined, truncate otherwise).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a new operand
// S_NORM  | shifting magnitude left until its top fraction bit is set
// S_ROUND | extracting frac/g/r/s, rounding, registering the result
// S_DONE  | result valid, held until the consumer takes it
module int_to_fp
  import int_to_fp_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   int_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [FRAC_W-1:0] frac_out,
  output logic              ovf
);

  state_t              state_q, state_d;
  logic [IN_W-1:0]     mag_q, mag_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                sign_q, sign_d;
  logic                res_sign_q, res_sign_d;
  logic [EXP_W-1:0]    res_exp_q, res_exp_d;
  logic [FRAC_W-1:0]   res_frac_q, res_frac_d;
  logic                res_ovf_q, res_ovf_d;

  // Magnitude below its sign-weight bit, zero-padded so g/r/s exist for every IN_W.
  logic [IN_W+1:0]     ext;
  logic [FRAC_W-1:0]   rnd_frac;
  logic [EXP_W-1:0]    rnd_exp;
  logic                rnd_ovf;

  assign ext = {mag_q[IN_W-2:0], 3'b000};

  fp_round_rne u_round (
    .frac_i (ext[IN_W+1 -: FRAC_W]),
    .exp_i  (exp_q),
    .g_i    (ext[IN_W-7]),
    .r_i    (ext[IN_W-8]),
    .s_i    (|ext[IN_W-9:0]),
    .frac_o (rnd_frac),
    .exp_o  (rnd_exp),
    .ovf_o  (rnd_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mag_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      res_sign_q <= 1'b0;
      res_exp_q  <= '0;
      res_frac_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      res_sign_q <= res_sign_d;
      res_exp_q  <= res_exp_d;
      res_frac_q <= res_frac_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    res_sign_d = res_sign_q;
    res_exp_d  = res_exp_q;
    res_frac_d = res_frac_q;
    res_ovf_d  = res_ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = int_in[IN_W-1];
          mag_d   = int_in[IN_W-1] ? -int_in : int_in;
          exp_d   = EXP_W'(IN_W-1);
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mag_q == '0 || mag_q[IN_W-1] || mag_q[IN_W-2]) begin
          state_d = S_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 4'd1;
        end
      end
      S_ROUND: begin
        if (mag_q == '0) begin
          res_sign_d = 1'b0;
          res_exp_d  = '0;
          res_frac_d = '0;
          res_ovf_d  = 1'b0;
        end else if (mag_q[IN_W-1]) begin
          // Only the most-negative input has a magnitude that does not fit IN_W-1 bits.
          res_sign_d = sign_q;
          res_exp_d  = EXP_MAX;
          res_frac_d = FRAC_MAX;
          res_ovf_d  = 1'b1;
        end else begin
          res_sign_d = sign_q;
          res_exp_d  = rnd_exp;
          res_frac_d = rnd_frac;
          res_ovf_d  = rnd_ovf;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sign_out  = res_sign_q;
  assign exp_out   = res_exp_q;
  assign frac_out  = res_frac_q;
  assign ovf       = res_ovf_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp (IN_W=16): directed, randomized vs. arithmetic model,
// backpressure and mid-conversion reset.
module tb_int_to_fp;

  localparam int IN_W = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] int_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [3:0]  exp_out;
  logic [7:0]  frac_out;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int_to_fp #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .int_in    (int_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .frac_out  (frac_out),
    .ovf       (ovf)
  );

  // Value-level reference: result approximates |v| as 0.f * 2^e with f in [128,255].
  function automatic void model(input int v, output logic s, output logic [3:0] e,
                                output logic [7:0] f, output logic o, output int lat);
    int m, bl, sh, fi, rem, half, ei;
    s = 1'b0; e = 4'd0; f = 8'd0; o = 1'b0; lat = 2;
    if (v == 0) return;
    s = (v < 0);
    m = (v < 0) ? -v : v;
    if (m >= (1 << (IN_W-1))) begin
      e = 4'hF; f = 8'hFF; o = 1'b1;
      return;
    end
    bl = 0;
    while ((1 << bl) <= m) bl++;
    lat = (IN_W-1 - bl) + 2;
    if (bl > 8) begin
      sh   = bl - 8;
      fi   = m >> sh;
      rem  = m - (fi << sh);
      half = 1 << (sh - 1);
`ifdef I2F_ROUND_EN
      if (rem > half || (rem == half && (fi % 2) == 1)) fi++;
`endif
    end else begin
      fi = m << (8 - bl);
    end
    ei = bl;
    if (fi == 256) begin
      fi = 128;
      ei++;
    end
    if (ei > 15) begin
      e = 4'hF; f = 8'hFF; o = 1'b1;
    end else begin
      e = 4'(ei); f = 8'(fi);
    end
  endfunction

  task automatic convert(input int v, input bit release_out, output logic s, output logic [3:0] e,
                         output logic [7:0] f, output logic o, output int lat);
    int guard;
    @(negedge clk);
    int_in    = 16'(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout v=%0d: out_valid never rose, waited %0d edges", v, lat);
    end
    s = sign_out; e = exp_out; f = frac_out; o = ovf;
    if (release_out) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; int_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, in_ready, sign_out, exp_out, frac_out, ovf} !== {1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ir=%b s=%b e=%h f=%h o=%b, want ov=0 ir=1 s=0 e=0 f=00 o=0",
               out_valid, in_ready, sign_out, exp_out, frac_out, ovf);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    int         v;
    logic       s;
    logic [3:0] e;
    logic [7:0] f;
    logic       o;
    int         lat;
  } dir_t;

  task automatic test_directed;
    dir_t tbl[$];
    logic s; logic [3:0] e; logic [7:0] f; logic o; int lat;
    tbl.push_back('{1,      1'b0, 4'd1,  8'h80, 1'b0, 16});
    tbl.push_back('{300,    1'b0, 4'd9,  8'h96, 1'b0, 8});
    tbl.push_back('{-300,   1'b1, 4'd9,  8'h96, 1'b0, 8});
    tbl.push_back('{0,      1'b0, 4'd0,  8'h00, 1'b0, 2});
    tbl.push_back('{-32768, 1'b1, 4'd15, 8'hFF, 1'b1, 2});
    tbl.push_back('{385,    1'b0, 4'd9,  8'hC0, 1'b0, 8});
`ifdef I2F_ROUND_EN
    tbl.push_back('{387,    1'b0, 4'd9,  8'hC2, 1'b0, 8});
    tbl.push_back('{511,    1'b0, 4'd10, 8'h80, 1'b0, 8});
    tbl.push_back('{32767,  1'b0, 4'd15, 8'hFF, 1'b1, 2});
`else
    tbl.push_back('{387,    1'b0, 4'd9,  8'hC1, 1'b0, 8});
    tbl.push_back('{511,    1'b0, 4'd9,  8'hFF, 1'b0, 8});
    tbl.push_back('{32767,  1'b0, 4'd15, 8'hFF, 1'b0, 2});
`endif
    foreach (tbl[i]) begin
      convert(tbl[i].v, 1'b1, s, e, f, o, lat);
      n_tests++;
      if ({s, e, f, o} !== {tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].o}) begin
        n_fail++;
        $display("FAIL directed v=%0d: got s=%b e=%0d f=%h o=%b, want s=%b e=%0d f=%h o=%b",
                 tbl[i].v, s, e, f, o, tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].o);
      end
      n_tests++;
      if (lat != tbl[i].lat) begin
        n_fail++;
        $display("FAIL latency v=%0d: got %0d edges, want %0d", tbl[i].v, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_random;
    logic s, es; logic [3:0] e, ee; logic [7:0] f, ef; logic o, eo; int lat, elat;
    int v;
    for (int i = 0; i < 150; i++) begin
      v = int'($signed(16'($urandom))) >>> $urandom_range(0, 15);
      model(v, es, ee, ef, eo, elat);
      convert(v, 1'b1, s, e, f, o, lat);
      n_tests++;
      if ({s, e, f, o} !== {es, ee, ef, eo} || lat != elat) begin
        n_fail++;
        $display("FAIL random v=%0d: got s=%b e=%0d f=%h o=%b lat=%0d, want s=%b e=%0d f=%h o=%b lat=%0d",
                 v, s, e, f, o, lat, es, ee, ef, eo, elat);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic s; logic [3:0] e; logic [7:0] f; logic o; int lat; int guard;
    convert(300, 1'b0, s, e, f, o, lat);
    // A new operand waits at the input the whole time the result is held.
    int_in   = 16'(-300);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, in_ready, sign_out, exp_out, frac_out, ovf} !== {1'b1, 1'b0, 1'b0, 4'd9, 8'h96, 1'b0}) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got ov=%b ir=%b s=%b e=%0d f=%h o=%b, want ov=1 ir=0 s=0 e=9 f=96 o=0",
                 k, out_valid, in_ready, sign_out, exp_out, frac_out, ovf);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL release: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_accept: got ir=%b, want ir=0", in_ready);
    end
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_tests++;
    if ({out_valid, sign_out, exp_out, frac_out, ovf} !== {1'b1, 1'b1, 4'd9, 8'h96, 1'b0}) begin
      n_fail++;
      $display("FAIL second_result: got ov=%b s=%b e=%0d f=%h o=%b, want ov=1 s=1 e=9 f=96 o=0",
               out_valid, sign_out, exp_out, frac_out, ovf);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic s; logic [3:0] e; logic [7:0] f; logic o; int lat;
    @(negedge clk);
    int_in   = 16'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, in_ready, sign_out, exp_out, frac_out, ovf} !== {1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: got ov=%b ir=%b s=%b e=%h f=%h o=%b, want ov=0 ir=1 all zero",
               out_valid, in_ready, sign_out, exp_out, frac_out, ovf);
    end
    @(negedge clk);
    reset_n = 1'b1;
    convert(-300, 1'b1, s, e, f, o, lat);
    n_tests++;
    if ({s, e, f, o} !== {1'b1, 4'd9, 8'h96, 1'b0} || lat != 8) begin
      n_fail++;
      $display("FAIL after_reset: got s=%b e=%0d f=%h o=%b lat=%0d, want s=1 e=9 f=96 o=0 lat=8",
               s, e, f, o, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
